// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter and long-latency scoreboard for the 32x32 register file.
// Two writeback requesters share the single registered write port (we3/wa3/wd3).
module rf_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    // Port 0: in-order pipeline writeback
    input  logic        r0_valid,
    input  logic [4:0]  r0_addr,
    input  logic [31:0] r0_data,
    output logic        r0_ready,

    // Port 1: long-latency mult/div writeback
    input  logic        r1_valid,
    input  logic [4:0]  r1_addr,
    input  logic [31:0] r1_data,
    output logic        r1_ready,

    // Issue-stage reservation of a long-latency destination
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,

    // Decode-stage hazard lookup
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy1,
    output logic        busy2,

    // Register-file write port
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        we3_q, we3_d;
    logic [4:0]  wa3_q, wa3_d;
    logic [31:0] wd3_q, wd3_d;
    logic [31:0] pending_q, pending_d;

    logic        force1;
    logic        xfer0;
    logic        xfer1;

    // Port 0 has fixed priority unless port 1 has aged out.
    assign force1   = r1_valid && (wait_cnt_q == MaxWait);
    assign r1_ready = r1_valid && (!r0_valid || force1);
    assign r0_ready = r0_valid && !force1;

    assign xfer0 = r0_valid && r0_ready;
    assign xfer1 = r1_valid && r1_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wait_cnt_d = wait_cnt_q;
        if (!r1_valid || xfer1) begin
            wait_cnt_d = '0;
        end else if (r0_valid && r0_ready) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // A write to $0 completes the handshake but never raises we3.
    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (xfer1) begin
            we3_d = (r1_addr != 5'd0);
            wa3_d = r1_addr;
            wd3_d = r1_data;
        end else if (xfer0) begin
            we3_d = (r0_addr != 5'd0);
            wa3_d = r0_addr;
            wd3_d = r0_data;
        end
    end

    // Clear follows the committed write; a same-edge reservation wins over it.
    always_comb begin
        pending_d = pending_q;
        if (we3_q) begin
            pending_d[wa3_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != 5'd0)) begin
            pending_d[rsv_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            we3_q      <= 1'b0;
            wa3_q      <= '0;
            wd3_q      <= '0;
            pending_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            wait_cnt_q <= wait_cnt_d;
            we3_q      <= we3_d;
            wa3_q      <= wa3_d;
            wd3_q      <= wd3_d;
            pending_q  <= pending_d;
        end
    end

    assign busy1 = pending_q[ra1];
    assign busy2 = pending_q[ra2];

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grant/aging, write port timing, scoreboard, reset.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, rsv_valid;
    logic [4:0]  r0_addr, r1_addr, rsv_addr, ra1, ra2;
    logic [31:0] r0_data, r1_data;

    logic        r0_ready, r1_ready, busy1, busy2, we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;

    logic        z_r0_ready, z_r1_ready, z_busy1, z_busy2, z_we3;
    logic [4:0]  z_wa3;
    logic [31:0] z_wd3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.MAX_WAIT(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
        .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    // Same stimulus, zero aging budget: port 1 must win every contended cycle.
    rf_wb_arbiter #(.MAX_WAIT(0)) u_dut_mw0 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(z_r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(z_r1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .ra1(ra1), .ra2(ra2), .busy1(z_busy1), .busy2(z_busy2),
        .we3(z_we3), .wa3(z_wa3), .wd3(z_wd3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
        r1_valid = 1'b0; r1_addr = '0; r1_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; ra1 = '0; ra2 = '0;

        #1;
        check("rst_we3", 32'(we3), 32'd0);
        check("rst_wa3", 32'(wa3), 32'd0);
        check("rst_wd3", wd3, 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        // Single port 0 write
        r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hDEADBEEF;
        #1;
        check("p0_ready", 32'(r0_ready), 32'd1);
        check("p0_r1_idle", 32'(r1_ready), 32'd0);
        tick();
        r0_valid = 1'b0;
        check("p0_we3", 32'(we3), 32'd1);
        check("p0_wa3", 32'(wa3), 32'd5);
        check("p0_wd3", wd3, 32'hDEADBEEF);
        tick();
        check("p0_we3_drop", 32'(we3), 32'd0);
        check("p0_wa3_hold", 32'(wa3), 32'd5);
        check("p0_wd3_hold", wd3, 32'hDEADBEEF);

        // Continuous contention: 0,0,0,1 grant pattern repeating
        r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h11111111;
        r1_valid = 1'b1; r1_addr = 5'd2; r1_data = 32'h22222222;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("age_r0_c%0d", c), 32'(r0_ready), (c % 4 == 3) ? 32'd0 : 32'd1);
            check($sformatf("age_r1_c%0d", c), 32'(r1_ready), (c % 4 == 3) ? 32'd1 : 32'd0);
            check($sformatf("mw0_r1_c%0d", c), 32'(z_r1_ready), 32'd1);
            check($sformatf("mw0_r0_c%0d", c), 32'(z_r0_ready), 32'd0);
            tick();
            check($sformatf("age_wa3_c%0d", c), 32'(wa3), (c % 4 == 3) ? 32'd2 : 32'd1);
            check($sformatf("age_wd3_c%0d", c), wd3,
                  (c % 4 == 3) ? 32'h22222222 : 32'h11111111);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();

        // Reservation of $9, cleared by a later port 1 write
        rsv_valid = 1'b1; rsv_addr = 5'd9; ra1 = 5'd9; ra2 = 5'd9;
        #1;
        check("rsv_busy1_pre", 32'(busy1), 32'd0);
        tick();
        rsv_valid = 1'b0;
        check("rsv_busy1", 32'(busy1), 32'd1);
        check("rsv_busy2", 32'(busy2), 32'd1);
        tick();
        check("rsv_busy1_hold", 32'(busy1), 32'd1);
        r1_valid = 1'b1; r1_addr = 5'd9; r1_data = 32'h0000CAFE;
        #1;
        check("rsv_r1_ready", 32'(r1_ready), 32'd1);
        tick();
        r1_valid = 1'b0;
        check("rsv_we3", 32'(we3), 32'd1);
        check("rsv_wa3", 32'(wa3), 32'd9);
        check("rsv_busy1_wecyc", 32'(busy1), 32'd1);
        tick();
        check("rsv_busy1_clr", 32'(busy1), 32'd0);
        check("rsv_busy2_clr", 32'(busy2), 32'd0);

        // Writes and reservations to $0
        r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'h00001234;
        #1;
        check("z_r1_ready", 32'(r1_ready), 32'd1);
        tick();
        r1_valid = 1'b0;
        check("z_we3", 32'(we3), 32'd0);
        check("z_wd3", wd3, 32'h00001234);
        rsv_valid = 1'b1; rsv_addr = 5'd0; ra1 = 5'd0;
        tick();
        rsv_valid = 1'b0;
        check("z_busy1", 32'(busy1), 32'd0);

        // Set and clear of $7 on the same edge: set wins
        rsv_valid = 1'b1; rsv_addr = 5'd7; ra2 = 5'd7;
        tick();
        rsv_valid = 1'b0;
        r0_valid = 1'b1; r0_addr = 5'd7; r0_data = 32'h77777777;
        tick();
        r0_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        check("sc_we3", 32'(we3), 32'd1);
        check("sc_wa3", 32'(wa3), 32'd7);
        tick();
        rsv_valid = 1'b0;
        check("sc_busy2", 32'(busy2), 32'd1);
        tick();
        check("sc_busy2_hold", 32'(busy2), 32'd1);

        // Asynchronous reset while a write is in flight and $7 is pending
        r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'h33333333;
        ra1 = 5'd7;
        tick();
        r0_valid = 1'b0;
        check("ar_we3_pre", 32'(we3), 32'd1);
        check("ar_busy1_pre", 32'(busy1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_we3", 32'(we3), 32'd0);
        check("ar_busy1", 32'(busy1), 32'd0);
        check("ar_busy2", 32'(busy2), 32'd0);
        check("ar_wd3", wd3, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("ar_busy2_post", 32'(busy2), 32'd0);
        check("ar_we3_post", 32'(we3), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. Shares the file's single write port (`we3`/`wa3`/`wd3`) between two writeback requesters: the in-order pipeline writeback (port 0) and the long-latency mult/div unit (port 1). It tracks registers with outstanding long-latency writes so the decode stage can stall on read-after-write hazards. The block sits between the writeback sources and the register file and drives the file's write port from registers.

## Interface
- `MAX_WAIT`, default 3: maximum consecutive contended cycles port 1 may lose before it is forced a grant; range 0..15.
- `clk`  in  1  system clock, rising-edge active; the register file writes on the falling edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `r0_valid`  in  1  pipeline writeback request.
- `r0_addr`  in  5  destination register for port 0.
- `r0_data`  in  32  write data for port 0.
- `r0_ready`  out  1  grant to port 0; combinational.
- `r1_valid`  in  1  mult/div writeback request.
- `r1_addr`  in  5  destination register for port 1.
- `r1_data`  in  32  write data for port 1.
- `r1_ready`  out  1  grant to port 1; combinational.
- `rsv_valid`  in  1  issue stage reserves a destination for a long-latency op.
- `rsv_addr`  in  5  register being reserved.
- `ra1`, `ra2`  in  5 each  decode-stage read addresses.
- `busy1`, `busy2`  out  1 each  the corresponding read address has a pending write; combinational from `pending`.
- `we3`  out  1  register-file write enable; registered.
- `wa3`  out  5  register-file write address; registered.
- `wd3`  out  32  register-file write data; registered.

## Operation
- A transfer occurs on port k at a rising edge where `rk_valid && rk_ready`. At most one transfer happens per cycle.
- Grant is fixed priority to port 0, with an aging override:
  - `force1 = r1_valid && (wait_cnt == MAX_WAIT)`.
  - `r1_ready = r1_valid && (!r0_valid || force1)`.
  - `r0_ready = r0_valid && !force1`.
  - Neither ready is asserted without its own valid.
- `wait_cnt` (4 bits) updates as follows:
  - Increments when `r0_valid && r1_valid && r0_ready`, i.e. port 1 lost.
  - Clears when port 1 transfers or when `r1_valid` is low.
  - Otherwise holds.
  - It never exceeds `MAX_WAIT`.
  - With `MAX_WAIT = 0`, port 1 wins every contended cycle.
- On a transfer, the next edge loads `we3 = (addr != 0)`, `wa3 = addr`, `wd3 = data` from the granted port. With no transfer, `we3` is 0 and `wa3`/`wd3` hold their previous values.
- A write to `$0` is accepted (ready asserted, handshake completes) but produces `we3 = 0`.
- `pending[31:0]` scoreboard:
  - Set: at an edge with `rsv_valid` and `rsv_addr != 0`, set `pending[rsv_addr]`.
  - Clear: at an edge with `we3` high, clear `pending[wa3]`. This happens after the register file has committed the write on the preceding falling edge.
  - Set and clear of the same index at the same edge: set wins.
  - `pending[0]` is constant 0.
- `busyN = pending[raN]`. It is 0 for `raN = 0`.
- Port 0 writes do not clear reservations early. Only the registered write to that index clears its bit, regardless of source.

## Timing
- Grant latency is zero: `rk_ready` is valid in the same cycle as `rk_valid`.
- Transfer at edge N gives `we3`/`wa3`/`wd3` valid from edge N to edge N+1. The register file commits at the falling edge between them.
- The pending bit drops at edge N+1, so `busy` falls in the cycle in which the file already holds the new value.
- Worst-case port 1 wait under continuous port 0 traffic is `MAX_WAIT` cycles. Grant occurs in cycle `MAX_WAIT`+1.
- Reset (asynchronous assert, synchronous-safe release) clears all of the following:
  - `we3 = 0`, `wa3 = 0`, `wd3 = 0`.
  - `pending = 0`, `wait_cnt = 0`.
- After reset, `busy1`/`busy2` read 0. `r0_ready`/`r1_ready` follow the valids per the grant equations.
- A reset mid-operation drops any in-flight registered write (`we3` forced 0) and all reservations. Requesters must re-present their requests.

## Test plan
- Reset, then `r0_valid=1`, `r0_addr=5`, `r0_data=0xDEADBEEF` for one cycle -> `r0_ready=1`. Next cycle `we3=1`, `wa3=5`, `wd3=0xDEADBEEF`. The cycle after, `we3=0`.
- `r0_valid` and `r1_valid` held high continuously with `MAX_WAIT=3` -> port 0 granted for 3 cycles, port 1 granted in the 4th, `wait_cnt` returns to 0, and the pattern repeats.
- `rsv_valid`, `rsv_addr=9`; `ra1=9` -> `busy1=1` from the next cycle. A later port 1 transfer to 9 -> `busy1` stays 1 through the `we3` cycle and is 0 in the cycle after.
- Write to `$0` with `r1_addr=0`, `r1_data=0x1234` -> `r1_ready=1`, `we3=0` next cycle. `rsv_addr=0` -> `busy1=0` with `ra1=0`.
- Same edge: `rsv_valid`, `rsv_addr=7`, while `we3=1`, `wa3=7` -> `pending[7]` remains 1.
- Assert `rst_n=0` mid-cycle while `we3=1` and `pending` is nonzero -> `we3=0` and all `busy` outputs 0 immediately, without waiting for a clock edge.
